// File: rtl/pcx2mb_fifo_ctl.sv
// PCX-to-MicroBlaze entry-chain sequencer: PA/PX request staging, FSL drain of the head entry, grants, occupancy.
// Optional FSL stall counter is built when PCX2MB_STALL_CNT_EN is defined.
module pcx2mb_fifo_ctl #(
  parameter int DEPTH     = 9,
  parameter int PKT_WORDS = 5,
  parameter int CNT_W     = 4
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic [4:0]       spc_pcx_req_pq,
  input  logic             spc_pcx_atom_pq,
  output logic             any_req_pa,
  output logic [4:0]       req_dest_pa,
  output logic             req_atom_pa,
  output logic             any_req_px,
  output logic [4:0]       req_dest_px,
  output logic             req_atom_px,
  input  logic             head_active,
  input  logic [4:0]       head_dest,
  input  logic             next_active,
  output logic             load_data,
  output logic [2:0]       word_sel,
  output logic             fsl_write,
  output logic             fsl_ctrl,
  input  logic             fsl_full,
  output logic [4:0]       pcx_spc_grant_px,
  output logic [CNT_W-1:0] occupancy,
  output logic             buf_full,
  output logic             ovf_err,
  output logic [15:0]      stall_cnt
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [2:0]       LAST_WORD = 3'(PKT_WORDS - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);

  state_t     state, state_nxt;
  logic [2:0] word_sel_nxt;
  logic       occ_inc;

  // PA stage
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      any_req_pa  <= 1'b0;
      req_dest_pa <= '0;
      req_atom_pa <= 1'b0;
    end else begin
      any_req_pa  <= |spc_pcx_req_pq;
      req_dest_pa <= spc_pcx_req_pq;
      req_atom_pa <= spc_pcx_atom_pq;
    end
  end

  // PX stage
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      any_req_px  <= 1'b0;
      req_dest_px <= '0;
      req_atom_px <= 1'b0;
    end else begin
      any_req_px  <= any_req_pa;
      req_dest_px <= req_dest_pa;
      req_atom_px <= req_atom_pa;
    end
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      word_sel <= '0;
    end else begin
      state    <= state_nxt;
      word_sel <= word_sel_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    word_sel_nxt = word_sel;
    fsl_write    = 1'b0;
    load_data    = 1'b0;
    case (state)
      IDLE: begin
        word_sel_nxt = '0;
        if (head_active) state_nxt = SEND;
      end
      SEND: begin
        fsl_write = ~fsl_full;
        if (fsl_write) begin
          if (word_sel == LAST_WORD) begin
            // Pop on the last accepted word; chain straight into the next packet if present.
            load_data    = 1'b1;
            word_sel_nxt = '0;
            state_nxt    = next_active ? SEND : IDLE;
          end else begin
            word_sel_nxt = word_sel + 3'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fsl_ctrl = fsl_write & (word_sel == 3'd0);

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) pcx_spc_grant_px <= '0;
    else       pcx_spc_grant_px <= load_data ? head_dest : 5'b0;
  end

  // The second half of an atomic pair lands one cycle after the first, unless a new PA request collides.
  assign occ_inc = any_req_pa | (any_req_px & req_atom_px & ~any_req_pa);

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      occupancy <= '0;
      ovf_err   <= 1'b0;
    end else begin
      case ({occ_inc, load_data})
        2'b10: begin
          if (occupancy == DEPTH_C) ovf_err   <= 1'b1;
          else                      occupancy <= occupancy + CNT_W'(1);
        end
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign buf_full = (occupancy == DEPTH_C);

`ifdef PCX2MB_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((state == SEND) && fsl_full && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_pcx2mb_fifo_ctl.sv
// Self-checking bench for pcx2mb_fifo_ctl: entry-chain model, grant scoreboard, vector table and corner sequences.
module tb_pcx2mb_fifo_ctl;
  localparam int DEPTH = 9;
  localparam int PKT_WORDS = 5;
  localparam int CNT_W = 4;

  logic             rclk, reset;
  logic [4:0]       spc_pcx_req_pq;
  logic             spc_pcx_atom_pq;
  logic             any_req_pa, req_atom_pa, any_req_px, req_atom_px;
  logic [4:0]       req_dest_pa, req_dest_px;
  logic             head_active, next_active;
  logic [4:0]       head_dest;
  logic             load_data, fsl_write, fsl_ctrl, fsl_full;
  logic [2:0]       word_sel;
  logic [4:0]       pcx_spc_grant_px;
  logic [CNT_W-1:0] occupancy;
  logic             buf_full, ovf_err;
  logic [15:0]      stall_cnt;

  pcx2mb_fifo_ctl #(.DEPTH(DEPTH), .PKT_WORDS(PKT_WORDS), .CNT_W(CNT_W)) dut (
    .rclk(rclk), .reset(reset),
    .spc_pcx_req_pq(spc_pcx_req_pq), .spc_pcx_atom_pq(spc_pcx_atom_pq),
    .any_req_pa(any_req_pa), .req_dest_pa(req_dest_pa), .req_atom_pa(req_atom_pa),
    .any_req_px(any_req_px), .req_dest_px(req_dest_px), .req_atom_px(req_atom_px),
    .head_active(head_active), .head_dest(head_dest), .next_active(next_active),
    .load_data(load_data), .word_sel(word_sel), .fsl_write(fsl_write), .fsl_ctrl(fsl_ctrl),
    .fsl_full(fsl_full), .pcx_spc_grant_px(pcx_spc_grant_px), .occupancy(occupancy),
    .buf_full(buf_full), .ovf_err(ovf_err), .stall_cnt(stall_cnt)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0] req;
    logic       atom;
    logic       exp_any;
    logic [4:0] exp_dest;
    logic       exp_atom;
  } vec_t;

  vec_t tv[9];

  int n_checks = 0;
  int n_fail = 0;
  logic [4:0] chain[$];
  logic [4:0] exp_grant_q[$];
  int ctrl_pos[$];
  int wcnt, n_writes, n_ctrl, n_loads, n_grants, cyc, first_wr, last_wr, load_cyc, grant_cyc;
  logic saw_load, saw_pa;
  int exp_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    n_writes = 0; n_ctrl = 0; n_loads = 0; n_grants = 0;
    first_wr = -1; last_wr = -1; load_cyc = -1; grant_cyc = -1;
    ctrl_pos.delete();
  endtask

  // One clock: drive at negedge, observe combinational/registered outputs, advance the chain model.
  task automatic cycle(input logic [4:0] req, input logic atom, input logic full);
    @(negedge rclk);
    spc_pcx_req_pq  = req;
    spc_pcx_atom_pq = atom;
    fsl_full        = full;
    head_active     = (chain.size() > 0);
    head_dest       = (chain.size() > 0) ? chain[0] : 5'd0;
    next_active     = (chain.size() > 1);
    if (req != 5'd0) begin
      exp_grant_q.push_back(req);
      if (atom) exp_grant_q.push_back(req);
    end
    #1;
    cyc++;
    if (fsl_write) begin
      chk("write_while_full", 32'(fsl_full), 0);
      chk("fsl_ctrl", 32'(fsl_ctrl), 32'(wcnt == 0));
      chk("load_on_last_word", 32'(load_data), 32'(wcnt == PKT_WORDS - 1));
      if (fsl_ctrl) begin
        n_ctrl++;
        ctrl_pos.push_back(n_writes);
      end
      n_writes++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      wcnt = (wcnt == PKT_WORDS - 1) ? 0 : wcnt + 1;
    end else begin
      chk("load_without_write", 32'(load_data), 0);
    end
    if (load_data) begin
      n_loads++;
      load_cyc = cyc;
    end
    if (pcx_spc_grant_px != 5'd0) begin
      n_grants++;
      grant_cyc = cyc;
      if (exp_grant_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL grant_unexpected: got %0h expected none", pcx_spc_grant_px);
      end else begin
        chk("grant", 32'(pcx_spc_grant_px), 32'(exp_grant_q.pop_front()));
      end
    end
    saw_load = load_data;
    saw_pa   = any_req_pa;
    if (load_data && chain.size() > 0) void'(chain.pop_front());
    if (any_req_pa) begin
      if (chain.size() < DEPTH) chain.push_back(req_dest_pa);
    end else if (any_req_px && req_atom_px && chain.size() < DEPTH) begin
      chain.push_back(req_dest_px);
    end
    @(posedge rclk);
    #1;
  endtask

  // Asynchronous reset between edges; outputs are checked before any clock edge occurs.
  task automatic do_reset();
    @(negedge rclk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_any_pa", 32'(any_req_pa), 0);
    chk("rst_dest_pa", 32'(req_dest_pa), 0);
    chk("rst_atom_pa", 32'(req_atom_pa), 0);
    chk("rst_any_px", 32'(any_req_px), 0);
    chk("rst_dest_px", 32'(req_dest_px), 0);
    chk("rst_atom_px", 32'(req_atom_px), 0);
    chk("rst_word_sel", 32'(word_sel), 0);
    chk("rst_fsl_write", 32'(fsl_write), 0);
    chk("rst_fsl_ctrl", 32'(fsl_ctrl), 0);
    chk("rst_load", 32'(load_data), 0);
    chk("rst_grant", 32'(pcx_spc_grant_px), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_buf_full", 32'(buf_full), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chain.delete();
    exp_grant_q.delete();
    wcnt = 0;
    spc_pcx_req_pq = '0; spc_pcx_atom_pq = 1'b0; fsl_full = 1'b0;
    head_active = 1'b0; head_dest = '0; next_active = 1'b0;
    @(negedge rclk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
`ifdef PCX2MB_STALL_CNT_EN
    exp_stall = 3;
`else
    exp_stall = 0;
`endif
    reset = 1'b1;
    spc_pcx_req_pq = '0; spc_pcx_atom_pq = 1'b0; fsl_full = 1'b0;
    head_active = 1'b0; head_dest = '0; next_active = 1'b0;
    cyc = 0; wcnt = 0;
    clear_stats();
    do_reset();

    // Stage pipeline vectors with the FSL blocked.
    tv[0] = '{5'b00001, 1'b0, 1'b1, 5'b00001, 1'b0};
    tv[1] = '{5'b00010, 1'b0, 1'b1, 5'b00010, 1'b0};
    tv[2] = '{5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0};
    tv[3] = '{5'b10000, 1'b1, 1'b1, 5'b10000, 1'b1};
    tv[4] = '{5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0};
    tv[5] = '{5'b01000, 1'b0, 1'b1, 5'b01000, 1'b0};
    tv[6] = '{5'b00000, 1'b1, 1'b0, 5'b00000, 1'b1};
    tv[7] = '{5'b00100, 1'b1, 1'b1, 5'b00100, 1'b1};
    tv[8] = '{5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0};
    for (int i = 0; i < 9; i++) begin
      cycle(tv[i].req, tv[i].atom, 1'b1);
      chk($sformatf("vec%0d_any_pa", i), 32'(any_req_pa), 32'(tv[i].exp_any));
      chk($sformatf("vec%0d_dest_pa", i), 32'(req_dest_pa), 32'(tv[i].exp_dest));
      chk($sformatf("vec%0d_atom_pa", i), 32'(req_atom_pa), 32'(tv[i].exp_atom));
      if (i > 0) begin
        chk($sformatf("vec%0d_any_px", i), 32'(any_req_px), 32'(tv[i-1].exp_any));
        chk($sformatf("vec%0d_dest_px", i), 32'(req_dest_px), 32'(tv[i-1].exp_dest));
        chk($sformatf("vec%0d_atom_px", i), 32'(req_atom_px), 32'(tv[i-1].exp_atom));
      end
    end
    cycle(5'd0, 1'b0, 1'b1);
    cycle(5'd0, 1'b0, 1'b1);
    chk("vec_occ", 32'(occupancy), 7);
    chk("vec_no_writes", 32'(n_writes), 0);

    // Single packet, no back-pressure.
    do_reset();
    clear_stats();
    cycle(5'b00001, 1'b0, 1'b0);
    chk("t2_any_pa", 32'(any_req_pa), 1);
    chk("t2_dest_pa", 32'(req_dest_pa), 1);
    chk("t2_occ_pa", 32'(occupancy), 0);
    cycle(5'd0, 1'b0, 1'b0);
    chk("t2_occ_1", 32'(occupancy), 1);
    chk("t2_any_px", 32'(any_req_px), 1);
    for (int i = 0; i < 12; i++) cycle(5'd0, 1'b0, 1'b0);
    chk("t2_writes", 32'(n_writes), 5);
    chk("t2_ctrls", 32'(n_ctrl), 1);
    chk("t2_loads", 32'(n_loads), 1);
    chk("t2_grants", 32'(n_grants), 1);
    chk("t2_grant_timing", 32'(grant_cyc), 32'(load_cyc + 1));
    chk("t2_grant_q_empty", 32'(exp_grant_q.size()), 0);
    chk("t2_occ_0", 32'(occupancy), 0);
    chk("t2_buf_full", 32'(buf_full), 0);

    // Reset in the middle of a packet.
    clear_stats();
    cycle(5'b00010, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(5'd0, 1'b0, 1'b0);
    cycle(5'b01000, 1'b0, 1'b0);
    chk("t1_mid_word_sel", 32'(word_sel), 3);
    chk("t1_mid_any_pa", 32'(any_req_pa), 1);
    do_reset();

    // Back-pressure at word 2.
    clear_stats();
    cycle(5'b10000, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(5'd0, 1'b0, 1'b0);
      if (word_sel == 3'd2) break;
    end
    chk("t3_reach_ws2", 32'(word_sel), 2);
    for (int i = 0; i < 3; i++) begin
      cycle(5'd0, 1'b0, 1'b1);
      chk("t3_ws_hold", 32'(word_sel), 2);
    end
    chk("t3_writes_held", 32'(n_writes), 2);
    chk("t3_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    for (int i = 0; i < 10; i++) cycle(5'd0, 1'b0, 1'b0);
    chk("t3_writes", 32'(n_writes), 5);
    chk("t3_grants", 32'(n_grants), 1);
    chk("t3_grant_q_empty", 32'(exp_grant_q.size()), 0);

    // Two queued packets drain back to back.
    do_reset();
    clear_stats();
    cycle(5'b00001, 1'b0, 1'b1);
    cycle(5'b00010, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(5'd0, 1'b0, 1'b1);
    chk("t4_occ", 32'(occupancy), 2);
    for (int i = 0; i < 20; i++) cycle(5'd0, 1'b0, 1'b0);
    chk("t4_writes", 32'(n_writes), 10);
    chk("t4_consecutive", 32'(last_wr - first_wr), 9);
    chk("t4_ctrl_count", 32'(n_ctrl), 2);
    chk("t4_ctrl_pos0", 32'(ctrl_pos.size() > 0 ? ctrl_pos[0] : -1), 0);
    chk("t4_ctrl_pos1", 32'(ctrl_pos.size() > 1 ? ctrl_pos[1] : -1), 5);
    chk("t4_grants", 32'(n_grants), 2);
    chk("t4_grant_q_empty", 32'(exp_grant_q.size()), 0);
    chk("t4_occ_0", 32'(occupancy), 0);

    // Fill, overflow, and simultaneous push/pop at full.
    do_reset();
    clear_stats();
    for (int i = 0; i < 9; i++) cycle(5'(1 << (i % 5)), 1'b0, 1'b1);
    cycle(5'd0, 1'b0, 1'b1);
    cycle(5'd0, 1'b0, 1'b1);
    chk("t5_occ_9", 32'(occupancy), 9);
    chk("t5_buf_full", 32'(buf_full), 1);
    chk("t5_no_ovf", 32'(ovf_err), 0);
    cycle(5'b00001, 1'b0, 1'b1);
    cycle(5'd0, 1'b0, 1'b1);
    cycle(5'd0, 1'b0, 1'b1);
    chk("t5_ovf", 32'(ovf_err), 1);
    chk("t5_occ_hold", 32'(occupancy), 9);
    for (int i = 0; i < 20; i++) begin
      cycle(5'd0, 1'b0, 1'b0);
      if (word_sel == 3'd3) break;
    end
    chk("t5_reach_ws3", 32'(word_sel), 3);
    cycle(5'b00100, 1'b0, 1'b0);
    chk("t5_pa_armed", 32'(any_req_pa), 1);
    cycle(5'd0, 1'b0, 1'b0);
    chk("t5_pushpop_load", 32'(saw_load), 1);
    chk("t5_pushpop_pa", 32'(saw_pa), 1);
    chk("t5_pushpop_occ", 32'(occupancy), 9);
    chk("t5_ovf_sticky", 32'(ovf_err), 1);

    // Atomic pair occupies two entries.
    do_reset();
    clear_stats();
    cycle(5'b00100, 1'b1, 1'b0);
    chk("t6_any_pa", 32'(any_req_pa), 1);
    chk("t6_atom_pa", 32'(req_atom_pa), 1);
    cycle(5'd0, 1'b0, 1'b0);
    chk("t6_occ_1", 32'(occupancy), 1);
    chk("t6_atom_px", 32'(req_atom_px), 1);
    cycle(5'd0, 1'b0, 1'b0);
    chk("t6_occ_2", 32'(occupancy), 2);
    for (int i = 0; i < 20; i++) cycle(5'd0, 1'b0, 1'b0);
    chk("t6_writes", 32'(n_writes), 10);
    chk("t6_loads", 32'(n_loads), 2);
    chk("t6_grants", 32'(n_grants), 2);
    chk("t6_grant_q_empty", 32'(exp_grant_q.size()), 0);
    chk("t6_occ_0", 32'(occupancy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
